// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core widths and EX/MEM entry layout
package mips_pkg;

  localparam int MIPS_DATA_W = 32;
  localparam int MIPS_REG_W  = 5;

  // Field order here matches the packing order used by ex_mem_stage.
  typedef struct packed {
    logic [MIPS_DATA_W-1:0] result;
    logic                   zero;
    logic [MIPS_REG_W-1:0]  rd;
    logic                   reg_write;
    logic                   mem_read;
    logic                   mem_write;
    logic [MIPS_DATA_W-1:0] store_data;
    logic [MIPS_DATA_W-1:0] pc;
  } ex_mem_t;

  localparam int EX_MEM_W = $bits(ex_mem_t);

endpackage

// File: rtl/skid_buf2.sv
// rtl/skid_buf2.sv - generic two-entry valid/ready skid buffer
// MAIN drives the output and SKID catches one extra beat; in_ready depends only on registered state.
module skid_buf2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             accept;
  logic             pop;

  assign accept = in_valid & ~skid_valid_q;
  assign pop    = main_valid_q & out_ready;

  // Empty entries are zeroed so that downstream never sees stale control bits.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      main_data_d  = '0;
      skid_valid_d = 1'b0;
      skid_data_d  = '0;
    end else if (pop && skid_valid_q) begin
      main_valid_d = 1'b1;
      main_data_d  = skid_data_q;
      skid_valid_d = 1'b0;
      skid_data_d  = '0;
    end else if (pop || !main_valid_q) begin
      main_valid_d = accept;
      main_data_d  = accept ? in_data : '0;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX-to-MEM pipeline stage with skid buffer and overflow trap
// Overflow trap squash and EPC capture are built only when EX_MEM_TRAP_EN is defined.
module ex_mem_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = MIPS_DATA_W,
  parameter int REG_W  = MIPS_REG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_zero,
  input  logic              in_overflow,
  input  logic              in_ovf_chk,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic [DATA_W-1:0] out_store_data,
  output logic [DATA_W-1:0] out_pc,
  output logic              trap,
  output logic [DATA_W-1:0] trap_epc
);

  localparam int PAYLOAD_W = 3 * DATA_W + REG_W + 4;

  logic [PAYLOAD_W-1:0] in_payload;
  logic [PAYLOAD_W-1:0] out_payload;
  logic                 buf_in_ready;
  logic                 buf_out_valid;
  logic                 ovf_trap;

`ifdef EX_MEM_TRAP_EN
  logic              accept;
  logic              trap_q, trap_d;
  logic [DATA_W-1:0] epc_q, epc_d;

  assign ovf_trap = in_ovf_chk & in_overflow;
  // Flush drops the incoming beat, so a trapping instruction in a flush cycle never traps.
  assign accept   = in_valid & buf_in_ready & ~flush;

  always_comb begin
    trap_d = accept & ovf_trap;
    epc_d  = trap_d ? in_pc : epc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_q <= 1'b0;
      epc_q  <= '0;
    end else begin
      trap_q <= trap_d;
      epc_q  <= epc_d;
    end
  end

  assign trap     = trap_q;
  assign trap_epc = epc_q;
`else
  logic unused_trap_inputs;

  assign unused_trap_inputs = in_ovf_chk ^ in_overflow;
  assign ovf_trap           = 1'b0;
  assign trap               = 1'b0;
  assign trap_epc           = '0;
`endif

  // A trapping entry still retires in order, but with every architectural side effect removed.
  assign in_payload = {in_result, in_zero, in_rd,
                       in_reg_write & ~ovf_trap,
                       in_mem_read  & ~ovf_trap,
                       in_mem_write & ~ovf_trap,
                       in_store_data, in_pc};

  skid_buf2 #(
    .WIDTH(PAYLOAD_W)
  ) u_skid_buf2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (buf_in_ready),
    .in_data   (in_payload),
    .out_valid (buf_out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign in_ready  = buf_in_ready;
  assign out_valid = buf_out_valid;
  assign {out_result, out_zero, out_rd, out_reg_write, out_mem_read,
          out_mem_write, out_store_data, out_pc} = out_payload;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - self-checking bench for ex_mem_stage against a FIFO reference model
module tb_ex_mem_stage;

`ifdef EX_MEM_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [31:0] sd;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_result;
  logic        in_zero, in_overflow, in_ovf_chk;
  logic [4:0]  in_rd;
  logic        in_reg_write, in_mem_read, in_mem_write;
  logic [31:0] in_store_data, in_pc;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_mem_read, out_mem_write;
  logic [31:0] out_store_data, out_pc;
  logic        trap;
  logic [31:0] trap_epc;

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_zero(in_zero), .in_overflow(in_overflow),
    .in_ovf_chk(in_ovf_chk), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_store_data(in_store_data), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_rd(out_rd), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_store_data(out_store_data), .out_pc(out_pc), .trap(trap),
    .trap_epc(trap_epc)
  );

  always #5 clk = ~clk;

  ent_t        q[$];
  logic        exp_trap;
  logic [31:0] exp_epc;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("trap", trap, exp_trap);
    chk("trap_epc", trap_epc, exp_epc);
    if (q.size() > 0) begin
      chk("out_result", out_result, q[0].result);
      chk("out_zero", out_zero, q[0].zero);
      chk("out_rd", out_rd, q[0].rd);
      chk("out_store_data", out_store_data, q[0].sd);
      chk("out_pc", out_pc, q[0].pc);
    end
    chk("out_reg_write", out_reg_write, (q.size() > 0) ? q[0].rw : 1'b0);
    chk("out_mem_read", out_mem_read, (q.size() > 0) ? q[0].mr : 1'b0);
    chk("out_mem_write", out_mem_write, (q.size() > 0) ? q[0].mw : 1'b0);
  endtask

  function automatic ent_t mk(input logic [31:0] res, input logic [31:0] pc, input bit rw);
    ent_t e;
    e.result = res;
    e.zero   = (res == 32'd0);
    e.rd     = 5'($urandom);
    e.rw     = rw;
    e.mr     = 1'($urandom);
    e.mw     = 1'($urandom);
    e.sd     = $urandom;
    e.pc     = pc;
    return e;
  endfunction

  // Called just after a falling edge: check, drive, clock, advance the model.
  task automatic step(input ent_t e, input bit v, input bit ovf, input bit chk_en,
                      input bit fl, input bit ordy);
    bit   acc, pop, is_trap;
    ent_t s;
    check_outputs();
    in_valid = v; in_result = e.result; in_zero = e.zero; in_rd = e.rd;
    in_reg_write = e.rw; in_mem_read = e.mr; in_mem_write = e.mw;
    in_store_data = e.sd; in_pc = e.pc; in_overflow = ovf; in_ovf_chk = chk_en;
    flush = fl; out_ready = ordy;
    acc     = v && (q.size() < 2) && !fl;
    pop     = (q.size() > 0) && ordy;
    is_trap = TRAP_EN && ovf && chk_en;
    s = e;
    if (is_trap) begin
      s.rw = 1'b0; s.mr = 1'b0; s.mw = 1'b0;
    end
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(s);
    end
    exp_trap = acc && is_trap;
    if (exp_trap) exp_epc = e.pc;
    @(negedge clk);
  endtask

  initial begin
    ent_t idle;
    idle = mk(32'd0, 32'd0, 1'b0);
    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_zero = 1'b0; in_overflow = 1'b0;
    in_ovf_chk = 1'b0; in_rd = '0; in_reg_write = 1'b0; in_mem_read = 1'b0;
    in_mem_write = 1'b0; in_store_data = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    exp_trap = 1'b0; exp_epc = '0;

    // Reset: every output zero, in_ready high.
    @(negedge clk);
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst trap", trap, 0);
    chk("rst trap_epc", trap_epc, 0);
    chk("rst out_result", out_result, 0);
    chk("rst out_zero", out_zero, 0);
    chk("rst out_rd", out_rd, 0);
    chk("rst out_ctrl", {out_reg_write, out_mem_read, out_mem_write}, 0);
    chk("rst out_store_data", out_store_data, 0);
    chk("rst out_pc", out_pc, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Streaming 1..8 at full throughput.
    for (int i = 1; i <= 8; i++) step(mk(32'(i), 32'h0040_0000 + 32'(4 * i), 1'b1), 1, 0, 0, 0, 1);
    step(idle, 0, 0, 0, 0, 1);

    // Stall: A then B with out_ready low, then drain.
    step(mk(32'h10, 32'h0040_0100, 1'b1), 1, 0, 0, 0, 0);
    step(mk(32'h20, 32'h0040_0104, 1'b1), 1, 0, 0, 0, 0);
    chk("stall in_ready low", in_ready, 0);
    step(idle, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(idle, 0, 0, 0, 0, 1);

    // Signed overflow trap, then unsigned overflow.
    step(mk(32'h8000_0000, 32'h0040_0020, 1'b1), 1, 1, 1, 0, 1);
    chk("trap pulse", trap, TRAP_EN);
    step(mk(32'h8000_0000, 32'h0040_0024, 1'b1), 1, 1, 0, 0, 1);
    chk("unsigned ovf rw", out_reg_write, 1);
    step(idle, 0, 0, 0, 0, 1);

    // Back-to-back traps.
    step(mk(32'h7fff_ffff, 32'h0040_0030, 1'b1), 1, 1, 1, 0, 1);
    step(mk(32'h8000_0001, 32'h0040_0034, 1'b1), 1, 1, 1, 0, 1);
    step(idle, 0, 0, 0, 0, 1);

    // Flush with both entries full and a trapping beat presented.
    step(mk(32'h31, 32'h0040_0200, 1'b1), 1, 0, 0, 0, 0);
    step(mk(32'h32, 32'h0040_0204, 1'b1), 1, 0, 0, 0, 0);
    step(mk(32'h33, 32'h0040_0208, 1'b1), 1, 1, 1, 1, 1);
    chk("flush out_valid", out_valid, 0);
    chk("flush in_ready", in_ready, 1);
    step(mk(32'h34, 32'h0040_0210, 1'b1), 1, 0, 0, 1, 1);
    for (int i = 0; i < 2; i++) step(idle, 0, 0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(mk($urandom_range(3) == 0 ? 32'd0 : $urandom, $urandom, 1'($urandom)),
           $urandom_range(3) != 0, 1'($urandom), 1'($urandom),
           $urandom_range(15) == 0, $urandom_range(2) != 0);
    end

    // Asynchronous reset between edges with entries buffered.
    step(mk(32'h51, 32'h0040_0300, 1'b1), 1, 1, 1, 0, 0);
    step(mk(32'h52, 32'h0040_0304, 1'b1), 1, 0, 0, 0, 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", out_valid, 0);
    chk("async rst trap_epc", trap_epc, 0);
    chk("async rst in_ready", in_ready, 1);
    chk("async rst trap", trap, 0);
    chk("async rst out_ctrl", {out_reg_write, out_mem_read, out_mem_write}, 0);
    q.delete();
    exp_trap = 1'b0;
    exp_epc  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(mk($urandom, $urandom, 1'($urandom)), 1'($urandom), 1'($urandom),
           1'($urandom), 1'b0, 1'($urandom));
    end
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
